// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and presents fetched words to decode through the IF/ID register with a one-entry skid buffer.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_stall,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_instr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_if_instr;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;

    logic            w_handshake;
    logic            w_deliver;
    logic            w_out_free;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_unused_bits;

    // Request depends on registered state only; no request while the skid holds a word.
    assign o_imem_req        = (r_state == FETCH) && !r_skid_valid;
    assign o_imem_addr       = r_pc;
    assign w_handshake       = o_imem_req && i_imem_gnt;
    assign w_deliver         = (r_state == WAIT) && i_imem_rvalid && !i_redirect_valid;
    assign w_out_free        = !r_if_valid || !i_stall;
    assign w_redirect_target = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_bits     = ^i_redirect_pc[1:0];

    assign o_if_valid = r_if_valid;
    assign o_if_pc    = r_if_pc;
    assign o_if_instr = r_if_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A granted request in the redirect cycle is still outstanding, so its response must be drained.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (w_handshake) begin
                    w_next_state = i_redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (i_redirect_valid) begin
                    w_next_state = i_imem_rvalid ? FETCH : DRAIN;
                end else if (i_imem_rvalid) begin
                    w_next_state = FETCH;
                end
            end
            DRAIN: begin
                if (i_redirect_valid || i_imem_rvalid) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            if (i_redirect_valid) begin
                r_pc <= w_redirect_target;
            end else if (w_handshake) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_handshake) begin
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
        end else if (i_redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_skid_pc;
                r_if_instr <= r_skid_instr;
            end else if (w_deliver) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
                r_if_instr <= i_imem_rdata;
            end else begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
        end
    end

    // The skid only fills when decode is stalled on a valid word as the response lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else if (i_redirect_valid) begin
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid && w_out_free) begin
            r_skid_valid <= 1'b0;
        end else if (w_deliver && !w_out_free) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= r_req_pc;
            r_skid_instr <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected {pc, instr} pairs,
// a monitor pops and compares each word decode actually accepts.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b1;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        stall = 1'b0;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;

    int total = 0;
    int bad   = 0;

    logic [63:0] expQ[$];

    logic        memPending = 1'b0;
    logic [31:0] memAddr    = 32'h0;
    int          memCd      = 0;
    int          memLatency = 0;
    bit          memRandom  = 1'b0;
    int          gntHold    = 0;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_req       (imemReq),
        .o_imem_addr      (imemAddr),
        .i_imem_gnt       (imemGnt),
        .i_imem_rvalid    (imemRvalid),
        .i_imem_rdata     (imemRdata),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .i_stall          (stall),
        .o_if_valid       (ifValid),
        .o_if_pc          (ifPc),
        .o_if_instr       (ifInstr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
        stall         = st;
        redirectValid = rv;
        redirectPc    = rpc;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
        expQ.push_back({pc, instr});
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("rstReq",   32'(imemReq), 32'h0);
        checkOutput("rstAddr",  imemAddr,     32'h0);
        checkOutput("rstValid", 32'(ifValid), 32'h0);
        checkOutput("rstPc",    ifPc,         32'h0);
        checkOutput("rstInstr", ifInstr,      32'h0000_0013);
        rst = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d outputs still missing, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Memory model: one pending response, grant may be held off, latency fixed or random.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (memPending) begin
                if (memCd == 0) begin
                    imemRvalid = 1'b1;
                    imemRdata  = memAddr ^ 32'hA5A5_0000;
                    memPending = 1'b0;
                end else begin
                    memCd--;
                    imemRvalid = 1'b0;
                end
            end else begin
                imemRvalid = 1'b0;
            end
            if (gntHold > 0 && imemReq) begin
                imemGnt = 1'b0;
                gntHold--;
            end else begin
                imemGnt = 1'b1;
            end
            if (imemReq && imemGnt) begin
                checkOutput("oneOutstanding", 32'(memPending), 32'h0);
                memPending = 1'b1;
                memAddr    = imemAddr;
                memCd      = memRandom ? int'($urandom_range(0, 4)) : memLatency;
            end
        end
    end

    // Monitor: a word counts as consumed when valid, not stalled and not flushed by a redirect.
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (ifValid && !stall && !redirectValid && !rst) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedOutput: got pc=%h instr=%h, required none", ifPc, ifInstr);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("ifPc",    ifPc,    exp[63:32]);
                    checkOutput("ifInstr", ifInstr, exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic validPattern[9];
        int   n;
        validPattern = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        $display("[TB] scenario 1: free run, zero-wait memory");
        memLatency = 0;
        pushExp(32'h0000_0000, 32'hA5A5_0000);
        pushExp(32'h0000_0004, 32'hA5A5_0004);
        pushExp(32'h0000_0008, 32'hA5A5_0008);
        pushExp(32'h0000_000C, 32'hA5A5_000C);
        resetDut();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ifValidToggle%0d", k), 32'(ifValid), 32'(validPattern[k]));
        end
        waitDrain(50);

        $display("[TB] scenario 2: redirect while waiting");
        memLatency = 2;
        pushExp(32'h0000_0000, 32'hA5A5_0000);
        pushExp(32'h0000_0100, 32'hA5A5_0100);
        resetDut();
        n = 0;
        while (!(memPending && memAddr == 32'h4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachWaitPc4", 32'(memPending && memAddr == 32'h4), 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("drainNoReq", 32'(imemReq), 32'h0);
        n = 0;
        while (!imemReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("redirReq",  32'(imemReq), 32'h1);
        checkOutput("redirAddr", imemAddr,     32'h0000_0100);
        waitDrain(50);

        $display("[TB] scenario 3: stall with skid");
        memLatency = 0;
        pushExp(32'h0000_0000, 32'hA5A5_0000);
        pushExp(32'h0000_0004, 32'hA5A5_0004);
        pushExp(32'h0000_0008, 32'hA5A5_0008);
        pushExp(32'h0000_000C, 32'hA5A5_000C);
        resetDut();
        n = 0;
        while (!(ifValid && ifPc == 32'h4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachPc4", 32'(ifValid && ifPc == 32'h4), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("holdValid%0d", k), 32'(ifValid), 32'h1);
            checkOutput($sformatf("holdPc%0d", k),    ifPc,         32'h4);
            checkOutput($sformatf("holdNoReq%0d", k), 32'(imemReq), 32'h0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("skidOutPc",   ifPc,         32'h8);
        checkOutput("resumeReq",   32'(imemReq), 32'h1);
        checkOutput("resumeAddr",  imemAddr,     32'hC);
        waitDrain(50);

        $display("[TB] scenario 4: redirect with response and stall");
        memLatency = 0;
        pushExp(32'h0000_0200, 32'hA5A5_0200);
        resetDut();
        n = 0;
        while (!(ifValid && ifPc == 32'h0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachPc0", 32'(ifValid && ifPc == 32'h0), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("flushValid", 32'(ifValid), 32'h0);
        checkOutput("targetReq",  32'(imemReq), 32'h1);
        checkOutput("targetAddr", imemAddr,     32'h0000_0200);
        waitDrain(50);

        $display("[TB] scenario 5: grant held off, random latency");
        gntHold   = 3;
        memRandom = 1'b1;
        pushExp(32'h0000_0000, 32'hA5A5_0000);
        pushExp(32'h0000_0004, 32'hA5A5_0004);
        pushExp(32'h0000_0008, 32'hA5A5_0008);
        pushExp(32'h0000_000C, 32'hA5A5_000C);
        pushExp(32'h0000_0010, 32'hA5A5_0010);
        pushExp(32'h0000_0014, 32'hA5A5_0014);
        resetDut();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("gntWaitReq%0d", k),  32'(imemReq), 32'h1);
            checkOutput($sformatf("gntWaitAddr%0d", k), imemAddr,     32'h0);
        end
        @(negedge clk);
        checkOutput("grantedNoReq", 32'(imemReq), 32'h0);
        waitDrain(300);
        memRandom = 1'b0;

        $display("[TB] scenario 6: reset while waiting");
        memLatency = 3;
        pushExp(32'h0000_0000, 32'hA5A5_0000);
        pushExp(32'h0000_0004, 32'hA5A5_0004);
        resetDut();
        @(negedge clk);
        checkOutput("firstReq",  32'(imemReq), 32'h1);
        checkOutput("firstAddr", imemAddr,     32'h0);
        @(negedge clk);
        checkOutput("inWaitNoReq", 32'(imemReq), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("midRstReq",   32'(imemReq), 32'h0);
        checkOutput("midRstAddr",  imemAddr,     32'h0);
        checkOutput("midRstValid", 32'(ifValid), 32'h0);
        checkOutput("midRstPc",    ifPc,         32'h0);
        checkOutput("midRstInstr", ifInstr,      32'h0000_0013);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstReq",  32'(imemReq), 32'h1);
        checkOutput("postRstAddr", imemAddr,     32'h0);
        waitDrain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
